// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues single-outstanding word reads to instruction memory
// at the current PC and buffers {instruction, PC} pairs in a small FIFO
// that feeds decode through valid/ready. Fetch halts at ADDR_LIMIT.
module instr_fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_LIMIT = 32764
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  input  logic        instr_ready,
  input  logic        flush,
  output logic        halted
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W:0]     count;
  logic [PTR_W+1:0]   occ;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [31:0]        tag;
  logic               push;
  logic               pop;
  logic               at_limit;
  logic [31:0]        data_mem [DEPTH];
  logic [31:0]        pc_mem   [DEPTH];

  // The in-flight request already owns a slot, so it counts toward occupancy.
  assign occ      = (PTR_W+2)'(count) + (PTR_W+2)'(state == S_WAIT);
  assign at_limit = (pc_in >= ADDR_LIMIT);

  // A response is kept only when it answers a live request and no flush is pending.
  assign push = (state == S_WAIT) && imem_rvalid && !flush;
  assign pop  = instr_valid && instr_ready && !flush;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!flush) begin
          if (at_limit)                   state_next = S_HALT;
          else if (imem_req && imem_gnt)  state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) state_next = S_IDLE;
        else if (flush)  state_next = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) state_next = S_IDLE;
      end
      S_HALT: begin
        if (flush) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic; the request is masked by rst so reset silences it immediately.
  always_comb begin
    imem_req   = !rst && (state == S_IDLE) && !flush && !at_limit &&
                 (occ < (PTR_W+2)'(DEPTH));
    imem_addr  = imem_req ? pc_in : 32'd0;
    pc_advance = imem_req && imem_gnt;
    halted     = (state == S_HALT);
  end

  // Tag register: remembers the PC of the outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             tag <= 32'd0;
    else if (pc_advance) tag <= pc_in;
  end

  // FIFO pointers and count; flush clears them and overrides push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write.
  // NOTE: the storage array is deliberately not reset; instr_valid gates every
  // read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= tag;
    end
  end

  // Head outputs, forced to zero when the queue is empty.
  always_comb begin
    instr_valid = (count != '0);
    instr       = instr_valid ? data_mem[rd_ptr] : 32'd0;
    instr_pc    = instr_valid ? pc_mem[rd_ptr] : 32'd0;
    instr_pc4   = instr_valid ? (pc_mem[rd_ptr] + 32'd4) : 32'd0;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        instr_ready;
  logic        flush;
  logic        halted;

  int vectors     = 0;
  int miscompares = 0;

  logic auto_mem = 1'b0;
  logic auto_pc  = 1'b0;

  instr_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_pc4   (instr_pc4),
    .instr_ready (instr_ready),
    .flush       (flush),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Memory contents as seen by the bench: a fixed pattern of the address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the edge, outputs are read 2 after.
  // In auto modes the bench plays a zero-wait memory and a PC that steps by 4.
  task automatic tick();
    logic        granted;
    logic [31:0] gaddr;
    logic        adv;
    granted = imem_req && imem_gnt;
    gaddr   = imem_addr;
    adv     = pc_advance;
    @(posedge clk);
    #1;
    if (auto_pc && adv) pc_in = pc_in + 32'd4;
    if (auto_mem) begin
      imem_rvalid = granted;
      imem_rdata  = granted ? word(gaddr) : 32'd0;
    end
    #1;
  endtask

  // Manual single fetch from IDLE: grant now, respond next cycle.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    pc_in    = addr;
    imem_gnt = 1'b1;
    #1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    #1;
  endtask

  initial begin
    int          adv_cnt;
    int          pops;
    logic [31:0] exp_pc;

    rst         = 1'b1;
    pc_in       = 32'd0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    instr_ready = 1'b0;
    flush       = 1'b0;
    #12;
    check("rst_req",    32'(imem_req),    32'd0);
    check("rst_valid",  32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted),      32'd0);
    check("rst_pc4",    instr_pc4,        32'd0);
    rst = 1'b0;
    #1;

    // 1: streaming with a zero-wait memory.
    imem_gnt    = 1'b1;
    instr_ready = 1'b1;
    auto_mem    = 1'b1;
    auto_pc     = 1'b1;
    adv_cnt     = 0;
    pops        = 0;
    exp_pc      = 32'd0;
    for (int i = 0; i < 20; i++) begin
      if (adv_cnt == 3) imem_gnt = 1'b0;
      #1;
      if (pc_advance) adv_cnt++;
      if (instr_valid && instr_ready) begin
        check("s1_pc",    instr_pc,  exp_pc);
        check("s1_pc4",   instr_pc4, exp_pc + 32'd4);
        check("s1_instr", instr,     word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      tick();
    end
    check("s1_adv",  adv_cnt,          3);
    check("s1_pops", pops,             3);
    check("s1_req",  32'(imem_req),    32'd1);
    check("s1_addr", imem_addr,        32'd12);

    // 2: backpressure fills exactly DEPTH entries.
    instr_ready = 1'b0;
    pc_in       = 32'h40;
    imem_gnt    = 1'b1;
    adv_cnt     = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (pc_advance) adv_cnt++;
      tick();
    end
    check("s2_adv",   adv_cnt,          4);
    check("s2_req",   32'(imem_req),    32'd0);
    check("s2_valid", 32'(instr_valid), 32'd1);
    check("s2_head",  instr_pc,         32'h40);
    check("s2_instr", instr,            word(32'h40));
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    adv_cnt     = 0;
    for (int i = 0; i < 6; i++) begin
      if (pc_advance) adv_cnt++;
      tick();
    end
    check("s2_refill", adv_cnt,  1);
    check("s2_head2",  instr_pc, 32'h44);
    imem_gnt = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    auto_mem = 1'b0;
    auto_pc  = 1'b0;
    #1;
    check("s2_flushed", 32'(instr_valid), 32'd0);

    // 3: flush while a request is outstanding; late response is discarded.
    pc_in    = 32'h80;
    imem_gnt = 1'b1;
    #1;
    check("s3_adv", 32'(pc_advance), 32'd1);
    tick();
    imem_gnt = 1'b0;
    pc_in    = 32'h100;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("s3_drop_req", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    #1;
    check("s3_valid", 32'(instr_valid), 32'd0);
    check("s3_req",   32'(imem_req),    32'd1);
    check("s3_addr",  imem_addr,        32'h100);

    // 4: flush coincident with rvalid and a pop.
    fetch_one(32'h100, 32'h1111_1111);
    check("s4_head", instr, 32'h1111_1111);
    pc_in    = 32'h104;
    imem_gnt = 1'b1;
    #1;
    tick();
    imem_gnt    = 1'b0;
    instr_ready = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2222_2222;
    flush       = 1'b1;
    tick();
    instr_ready = 1'b0;
    imem_rvalid = 1'b0;
    flush       = 1'b0;
    #1;
    check("s4_valid", 32'(instr_valid), 32'd0);
    check("s4_idle",  32'(imem_req),    32'd1);
    tick();
    check("s4_valid2", 32'(instr_valid), 32'd0);

    // 5: halt at the address limit, drain, resume on flush.
    fetch_one(32'h200, 32'h0000_0200);
    fetch_one(32'h204, 32'h0000_0204);
    pc_in = 32'd32764;
    #1;
    check("s5_noreq", 32'(imem_req), 32'd0);
    tick();
    imem_gnt = 1'b1;
    #1;
    check("s5_halted", 32'(halted),     32'd1);
    check("s5_req",    32'(imem_req),   32'd0);
    check("s5_adv",    32'(pc_advance), 32'd0);
    instr_ready = 1'b1;
    check("s5_drain0", instr_pc, 32'h200);
    tick();
    check("s5_drain1", instr_pc, 32'h204);
    tick();
    instr_ready = 1'b0;
    check("s5_empty",   32'(instr_valid), 32'd0);
    check("s5_halted2", 32'(halted),      32'd1);
    imem_gnt = 1'b0;
    pc_in    = 32'd0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("s5_resume_h", 32'(halted),   32'd0);
    check("s5_resume_r", 32'(imem_req), 32'd1);
    check("s5_resume_a", imem_addr,     32'd0);

    // 6: asynchronous reset mid-WAIT with three entries queued.
    fetch_one(32'h300, 32'h3);
    fetch_one(32'h304, 32'h4);
    fetch_one(32'h308, 32'h5);
    pc_in    = 32'h30C;
    imem_gnt = 1'b1;
    #1;
    tick();
    check("s6_pre", 32'(instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("s6_adv",    32'(pc_advance),  32'd0);
    check("s6_req",    32'(imem_req),    32'd0);
    check("s6_addr",   imem_addr,        32'd0);
    check("s6_valid",  32'(instr_valid), 32'd0);
    check("s6_instr",  instr,            32'd0);
    check("s6_pc",     instr_pc,         32'd0);
    check("s6_pc4",    instr_pc4,        32'd0);
    check("s6_halted", 32'(halted),      32'd0);
    tick();
    rst      = 1'b0;
    imem_gnt = 1'b0;
    pc_in    = 32'h400;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("s6_stale", 32'(instr_valid), 32'd0);
    check("s6_idle",  32'(imem_req),    32'd1);
    check("s6_naddr", imem_addr,        32'h400);
    tick();
    check("s6_stale2", 32'(instr_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
